// File: rtl/vga_fill_arbiter.sv
// vga_fill_arbiter: merges CPU single-pixel writes and a rectangle-fill engine
// into one registered write port for the 3-bit video RAM. CPU writes always
// win the port; the fill engine stalls its cursor in any cycle with a CPU request.
module vga_fill_arbiter #(
  parameter int WIDTH       = 100,
  parameter int HEIGHT      = 100,
  parameter int ADDR_WIDTH  = 16,
  parameter int COORD_WIDTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iCpuWrite,
  input  logic [COORD_WIDTH-1:0] iCpuX,
  input  logic [COORD_WIDTH-1:0] iCpuY,
  input  logic [2:0]             iCpuColor,
  input  logic                   iFillStart,
  input  logic [COORD_WIDTH-1:0] iFillX0,
  input  logic [COORD_WIDTH-1:0] iFillY0,
  input  logic [COORD_WIDTH-1:0] iFillX1,
  input  logic [COORD_WIDTH-1:0] iFillY1,
  input  logic [2:0]             iFillColor,
  input  logic                   iFillAbort,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [2:0]             oDataIn,
  output logic                   oBusy,
  output logic                   oDone
);

  localparam logic [COORD_WIDTH-1:0] X_MAX    = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_MAX    = COORD_WIDTH'(HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] COORD_ONE = COORD_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  ROW_STEP = ADDR_WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] x0_q, x0_d;
  logic [COORD_WIDTH-1:0] y0_q, y0_d;
  logic [COORD_WIDTH-1:0] x1_q, x1_d;
  logic [COORD_WIDTH-1:0] y1_q, y1_d;
  logic [2:0]             color_q, color_d;
  logic [COORD_WIDTH-1:0] cur_x_q, cur_x_d;
  logic [COORD_WIDTH-1:0] cur_y_q, cur_y_d;
  logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [2:0]             data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   cpu_ok;
  logic [ADDR_WIDTH-1:0]  cpu_addr;
  logic [COORD_WIDTH-1:0] clamp_x0, clamp_y0, clamp_x1, clamp_y1;

  // Out-of-screen CPU writes are dropped; fill corners are clamped onto the screen.
  assign cpu_ok   = iCpuWrite && (int'(iCpuX) < WIDTH) && (int'(iCpuY) < HEIGHT);
  assign cpu_addr = ADDR_WIDTH'(iCpuY) * ROW_STEP + ADDR_WIDTH'(iCpuX);
  assign clamp_x0 = (int'(iFillX0) > WIDTH - 1)  ? X_MAX : iFillX0;
  assign clamp_x1 = (int'(iFillX1) > WIDTH - 1)  ? X_MAX : iFillX1;
  assign clamp_y0 = (int'(iFillY0) > HEIGHT - 1) ? Y_MAX : iFillY0;
  assign clamp_y1 = (int'(iFillY1) > HEIGHT - 1) ? Y_MAX : iFillY1;

  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oDataIn       = data_q;
  assign oBusy         = busy_q;
  assign oDone         = done_q;

  // Next-state logic: fill sequencing, cursor walk and write-port arbitration.
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    color_d    = color_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    row_base_d = row_base_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      IDLE: begin
        if (iFillStart) begin
          x0_d    = clamp_x0;
          y0_d    = clamp_y0;
          x1_d    = clamp_x1;
          y1_d    = clamp_y1;
          color_d = iFillColor;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (iFillAbort) begin
          state_d = IDLE;
        end else if ((x1_q < x0_q) || (y1_q < y0_q)) begin
          state_d = DONE;
        end else begin
          row_base_d = ADDR_WIDTH'(y0_q) * ROW_STEP;
          cur_x_d    = x0_q;
          cur_y_d    = y0_q;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (iFillAbort) begin
          state_d = IDLE;
        end else if (!iCpuWrite) begin
          we_d   = 1'b1;
          addr_d = row_base_q + ADDR_WIDTH'(cur_x_q);
          data_d = color_q;
          if (cur_x_q < x1_q) begin
            cur_x_d = cur_x_q + COORD_ONE;
          end else if (cur_y_q == y1_q) begin
            state_d = DONE;
          end else begin
            cur_x_d    = x0_q;
            cur_y_d    = cur_y_q + COORD_ONE;
            row_base_d = row_base_q + ROW_STEP;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cpu_ok) begin
      we_d   = 1'b1;
      addr_d = cpu_addr;
      data_d = iCpuColor;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers, cleared asynchronously by Reset low.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      row_base_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      color_q    <= color_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      row_base_q <= row_base_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_vga_fill_arbiter.sv
// tb_vga_fill_arbiter: directed scenarios plus random traffic, compared every
// cycle against a queue-based model of the rectangle fill and CPU writes.
module tb_vga_fill_arbiter;

  localparam int W = 100;
  localparam int H = 100;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iCpuWrite;
  logic [7:0]  iCpuX, iCpuY;
  logic [2:0]  iCpuColor;
  logic        iFillStart;
  logic [7:0]  iFillX0, iFillY0, iFillX1, iFillY1;
  logic [2:0]  iFillColor;
  logic        iFillAbort;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [2:0]  oDataIn;
  logic        oBusy;
  logic        oDone;

  int checks = 0;
  int errors = 0;

  // Reference model: pending fill addresses, a setup-cycle flag, a done-cycle flag.
  int         pend[$];
  bit         setupWait;
  bit         doneNow;
  logic [2:0] fillColor;
  bit         expWe, expBusy, expDone;
  int         expAddr;
  int         expData;

  int obsLog[$];
  bit weLog[$];
  bit doneLog[$];

  vga_fill_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuWrite(iCpuWrite), .iCpuX(iCpuX), .iCpuY(iCpuY), .iCpuColor(iCpuColor),
    .iFillStart(iFillStart), .iFillX0(iFillX0), .iFillY0(iFillY0),
    .iFillX1(iFillX1), .iFillY1(iFillY1), .iFillColor(iFillColor),
    .iFillAbort(iFillAbort),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oDataIn(oDataIn),
    .oBusy(oBusy), .oDone(oDone)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    pend.delete();
    setupWait = 0;
    doneNow   = 0;
    expWe     = 0;
    expBusy   = 0;
    expDone   = 0;
  endtask

  function automatic int clampTo(input int v, input int limit);
    return (v > limit - 1) ? limit - 1 : v;
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic modelStep();
    bit doneNext;
    int x0, y0, x1, y1;
    doneNext = 0;
    expWe    = 0;
    if (setupWait) begin
      setupWait = 0;
      if (iFillAbort) pend.delete();
      else if (pend.size() == 0) doneNext = 1;
    end else if (pend.size() > 0) begin
      if (iFillAbort) begin
        pend.delete();
      end else if (!iCpuWrite) begin
        expWe   = 1;
        expAddr = pend.pop_front();
        expData = int'(fillColor);
        if (pend.size() == 0) doneNext = 1;
      end
    end else if (!doneNow && iFillStart) begin
      x0 = clampTo(int'(iFillX0), W);
      x1 = clampTo(int'(iFillX1), W);
      y0 = clampTo(int'(iFillY0), H);
      y1 = clampTo(int'(iFillY1), H);
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++)
          pend.push_back(y * W + x);
      fillColor = iFillColor;
      setupWait = 1;
    end
    doneNow = doneNext;
    if (iCpuWrite && int'(iCpuX) < W && int'(iCpuY) < H) begin
      expWe   = 1;
      expAddr = int'(iCpuY) * W + int'(iCpuX);
      expData = int'(iCpuColor);
    end
    expDone = doneNow;
    expBusy = setupWait || (pend.size() > 0) || doneNow;
  endtask

  // One clock: edge, model update, compare 1ns later, log, then drop strobes.
  task automatic applyStimulus();
    @(posedge Clock);
    modelStep();
    #1;
    checkOutput("we", int'(oWriteEnable), int'(expWe));
    checkOutput("busy", int'(oBusy), int'(expBusy));
    checkOutput("done", int'(oDone), int'(expDone));
    if (expWe) begin
      checkOutput("addr", int'(oWriteAddress), expAddr);
      checkOutput("data", int'(oDataIn), expData);
    end
    if (oWriteEnable) obsLog.push_back(int'(oWriteAddress));
    weLog.push_back(oWriteEnable);
    doneLog.push_back(oDone);
    iCpuWrite  = 1'b0;
    iFillStart = 1'b0;
    iFillAbort = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic clearLogs();
    obsLog.delete();
    weLog.delete();
    doneLog.delete();
  endtask

  task automatic setFill(input int x0, input int y0, input int x1, input int y1,
                         input logic [2:0] c);
    iFillX0    = 8'(x0);
    iFillY0    = 8'(y0);
    iFillX1    = 8'(x1);
    iFillY1    = 8'(y1);
    iFillColor = c;
    iFillStart = 1'b1;
  endtask

  task automatic setCpu(input int x, input int y, input logic [2:0] c);
    iCpuX     = 8'(x);
    iCpuY     = 8'(y);
    iCpuColor = c;
    iCpuWrite = 1'b1;
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    int expFill[6];
    int expMix[7];
    int v;
    expFill = '{302, 303, 304, 402, 403, 404};
    expMix  = '{302, 0, 303, 304, 402, 403, 404};

    Reset = 1'b0;
    iCpuWrite = 0; iCpuX = 0; iCpuY = 0; iCpuColor = 0;
    iFillStart = 0; iFillX0 = 0; iFillY0 = 0; iFillX1 = 0; iFillY1 = 0;
    iFillColor = 0; iFillAbort = 0;
    modelReset();
    #12;
    checkOutput("rst_we", int'(oWriteEnable), 0);
    checkOutput("rst_addr", int'(oWriteAddress), 0);
    checkOutput("rst_data", int'(oDataIn), 0);
    checkOutput("rst_busy", int'(oBusy), 0);
    checkOutput("rst_done", int'(oDone), 0);
    #1 Reset = 1'b1;

    // CPU write in range, then column 100 which must be dropped.
    setCpu(7, 2, 3'b101);
    applyStimulus();
    checkOutput("cpu207_addr", int'(oWriteAddress), 207);
    checkOutput("cpu207_data", int'(oDataIn), 5);
    setCpu(100, 2, 3'b101);
    applyStimulus();
    checkOutput("cpu_drop_we", int'(oWriteEnable), 0);

    // Plain 3x2 fill.
    clearLogs();
    setFill(2, 3, 4, 4, 3'd6);
    applyStimulus();
    idleCycles(9);
    checkOutput("fill_count", obsLog.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < obsLog.size()) checkOutput("fill_order", obsLog[i], expFill[i]);
    checkOutput("fill_lat_early", int'(weLog[1]), 0);
    checkOutput("fill_lat_first", int'(weLog[2]), 1);

    // Same fill with a CPU write where the 303 write would land.
    clearLogs();
    setFill(2, 3, 4, 4, 3'd6);
    applyStimulus();
    idleCycles(2);
    setCpu(0, 0, 3'd1);
    applyStimulus();
    idleCycles(8);
    checkOutput("mix_count", obsLog.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < obsLog.size()) checkOutput("mix_order", obsLog[i], expMix[i]);

    // Inverted rectangle is rejected: done pulse only.
    clearLogs();
    setFill(5, 5, 4, 9, 3'd2);
    applyStimulus();
    idleCycles(4);
    checkOutput("rej_writes", obsLog.size(), 0);
    checkOutput("rej_done_early", int'(doneLog[0]), 0);
    checkOutput("rej_done", int'(doneLog[1]), 1);

    // Off-screen corners clamp to the last row.
    clearLogs();
    setFill(98, 99, 150, 200, 3'd3);
    applyStimulus();
    idleCycles(5);
    checkOutput("clamp_count", obsLog.size(), 2);
    if (obsLog.size() == 2) begin
      checkOutput("clamp_a", obsLog[0], 9998);
      checkOutput("clamp_b", obsLog[1], 9999);
    end

    // Restart during RUN is ignored; abort stops the fill silently.
    setFill(0, 0, 9, 9, 3'd4);
    applyStimulus();
    idleCycles(5);
    setFill(10, 10, 12, 12, 3'd7);
    applyStimulus();
    idleCycles(3);
    iFillAbort = 1'b1;
    applyStimulus();
    checkOutput("abort_busy", int'(oBusy), 0);
    clearLogs();
    idleCycles(3);
    checkOutput("abort_quiet", obsLog.size(), 0);

    // Asynchronous reset in the middle of a fill.
    setFill(0, 0, 9, 9, 3'd5);
    applyStimulus();
    idleCycles(4);
    #2 Reset = 1'b0;
    #1;
    checkOutput("async_we", int'(oWriteEnable), 0);
    checkOutput("async_busy", int'(oBusy), 0);
    checkOutput("async_done", int'(oDone), 0);
    modelReset();
    @(negedge Clock);
    Reset = 1'b1;
    idleCycles(2);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0)
        setCpu(int'($urandom_range(0, 110)), int'($urandom_range(0, 110)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 7) == 0) begin
        iFillX0 = 8'($urandom_range(0, 99));
        iFillY0 = 8'($urandom_range(0, 99));
        if ($urandom_range(0, 9) == 0) iFillX0 = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) iFillY0 = 8'($urandom_range(0, 255));
        v = int'(iFillX0) + int'($urandom_range(0, 4)) - 1;
        iFillX1 = 8'((v < 0) ? 0 : ((v > 255) ? 255 : v));
        v = int'(iFillY0) + int'($urandom_range(0, 3)) - 1;
        iFillY1 = 8'((v < 0) ? 0 : ((v > 255) ? 255 : v));
        iFillColor = 3'($urandom_range(0, 7));
        iFillStart = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) iFillAbort = 1'b1;
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
